// File: rtl/lsu_data_mem_if.sv
// Request/response bus between the core's MEM stage and lsu_data_mem.
interface lsu_data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_data_mem.sv
// RV32 data memory with LSU front end: byte/half/word stores with lane merge,
// sign/zero-extended loads, registered read, error response for bad accesses.
module lsu_data_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_data_mem_if.slave bus
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    mem [MEM_WORDS];

  logic [31:0]    off;
  logic [AW-1:0]  word_idx;
  logic [1:0]     lane;
  logic           out_of_range;
  logic           misaligned;
  logic           illegal;
  logic           req_err;
  logic           accept;
  logic           wr_en;
  logic [3:0]     byte_en;
  logic [31:0]    wr_data;
  logic [31:0]    mem_word;

  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic [31:0]    rd_word_q, rd_word_d;
  logic [1:0]     rd_lane_q, rd_lane_d;
  logic [2:0]     rd_funct3_q, rd_funct3_d;

  // Select the addressed byte/half and extend it according to funct3.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  ln,
                                          input logic [2:0]  fn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {ln, 3'b000};
    case (fn[1:0])
      2'b00:   res = fn[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = fn[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Address decode, error classification and store lane generation.
  always_comb begin
    off          = bus.req_addr - BASE_ADDR;
    // Below-base addresses wrap to a large off; the explicit compare catches them.
    out_of_range = (bus.req_addr < BASE_ADDR) || ({1'b0, off} >= MEM_BYTES);
    word_idx     = off[AW+1:2];
    lane         = off[1:0];
    illegal      = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && lane[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    req_err      = out_of_range || misaligned || illegal;
    accept       = bus.req_valid && (state_q == IDLE);
    wr_en        = accept && bus.req_we && !req_err;
    mem_word     = mem[word_idx];

    case (bus.req_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << lane;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        byte_en = '1;
        wr_data = bus.req_wdata;
      end
    endcase
  end

  // Storage array: per-byte write on the accept edge of a legal store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Request/response FSM and response data staging.
  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    rd_word_d    = rd_word_q;
    rd_lane_d    = rd_lane_q;
    rd_funct3_d  = rd_funct3_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || bus.req_we) begin
            state_d      = RESP;
            resp_err_d   = req_err;
            resp_rdata_d = '0;
          end else if (RD_LAT == 2) begin
            state_d      = RD1;
            resp_err_d   = 1'b0;
            rd_word_d    = mem_word;
            rd_lane_d    = lane;
            rd_funct3_d  = bus.req_funct3;
          end else begin
            state_d      = RESP;
            resp_err_d   = 1'b0;
            resp_rdata_d = extract(mem_word, lane, bus.req_funct3);
          end
        end
      end
      RD1: begin
        state_d      = RESP;
        resp_rdata_d = extract(rd_word_q, rd_lane_q, rd_funct3_q);
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      rd_word_q    <= '0;
      rd_lane_q    <= '0;
      rd_funct3_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      rd_word_q    <= rd_word_d;
      rd_lane_q    <= rd_lane_d;
      rd_funct3_q  <= rd_funct3_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: two instances (base 0 / RD_LAT 1 and base 0x1000 /
// RD_LAT 2) checked against a byte-array reference model.
module tb_lsu_data_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_data_mem_if ifa();
  lsu_data_mem_if ifb();

  lsu_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .RD_LAT(1))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  lsu_data_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_1000), .RD_LAT(2))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int          sel = 0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        rr = 1'b0;

  assign ifa.req_valid  = valid && (sel == 0);
  assign ifb.req_valid  = valid && (sel == 1);
  assign ifa.req_we     = we;
  assign ifb.req_we     = we;
  assign ifa.req_funct3 = f3;
  assign ifb.req_funct3 = f3;
  assign ifa.req_addr   = addr;
  assign ifb.req_addr   = addr;
  assign ifa.req_wdata  = wd;
  assign ifb.req_wdata  = wd;
  assign ifa.resp_ready = rr && (sel == 0);
  assign ifb.resp_ready = rr && (sel == 1);

  logic        o_qr, o_rv, o_er;
  logic [31:0] o_rd;
  assign o_qr = (sel == 1) ? ifb.req_ready  : ifa.req_ready;
  assign o_rv = (sel == 1) ? ifb.resp_valid : ifa.resp_valid;
  assign o_er = (sel == 1) ? ifb.resp_err   : ifa.resp_err;
  assign o_rd = (sel == 1) ? ifb.resp_rdata : ifa.resp_rdata;

  logic [7:0] mdl [2][4096];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  // Reference: decode by byte offset, update/read the byte array.
  task automatic model(input logic w, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] r,
                       output int unsigned l);
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] v;
    int unsigned nbytes;
    base   = (sel == 1) ? 32'h1000 : 32'h0;
    off    = a - base;
    nbytes = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    e = (fn == 3'b011) || (fn >= 3'b110) || (a < base) || (off >= 32'd4096) ||
        ((off % nbytes) != 0);
    r = '0;
    l = (w || e) ? 1 : ((sel == 1) ? 2 : 1);
    if (!e) begin
      if (w) begin
        for (int unsigned i = 0; i < nbytes; i++) mdl[sel][off + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < nbytes; i++) v[8*i +: 8] = mdl[sel][off + i];
        if (nbytes < 4 && !fn[2] && v[8*nbytes-1]) v = v | ~((32'h1 << (8*nbytes)) - 1);
        r = v;
      end
    end
  endtask

  // One full transaction; while holding the response, a store is offered that must be ignored.
  task automatic xact(input logic w, input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] d, input int unsigned hold);
    logic e;
    logic [31:0] r;
    int unsigned l;
    int unsigned lat;
    model(w, fn, a, d, e, r, l);
    @(negedge clk);
    check("req_ready_idle", o_qr, 1);
    valid = 1'b1; we = w; f3 = fn; addr = a; wd = d;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_rv && lat < 10);
    check("latency", lat, l);
    check("rdata", o_rd, r);
    check("err", o_er, e);
    check("req_ready_busy", o_qr, 0);
    for (int unsigned h = 0; h < hold; h++) begin
      valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = (sel == 1) ? 32'h1000 : 32'h0; wd = ~d;
      @(negedge clk);
      check("hold_valid", o_rv, 1);
      check("hold_rdata", o_rd, r);
      check("hold_err", o_er, e);
      check("hold_ready", o_qr, 0);
    end
    valid = 1'b0;
    rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
    @(negedge clk);
    check("resp_done", o_rv, 0);
  endtask

  task automatic preinit();
    for (int unsigned i = 0; i < 16; i++) xact(1'b1, 3'b010, 32'((sel == 1) ? 32'h1000 : 0) + 4*i, $urandom, 0);
    for (int unsigned i = 0; i < 16; i++) xact(1'b1, 3'b010, 32'((sel == 1) ? 32'h1000 : 0) + 32'hFC0 + 4*i, $urandom, 0);
  endtask

  task automatic random_ops(input int unsigned n);
    logic [31:0] base;
    logic [31:0] a;
    logic [2:0]  fn;
    logic        w;
    int unsigned k;
    base = (sel == 1) ? 32'h1000 : 32'h0;
    for (int unsigned i = 0; i < n; i++) begin
      k  = $urandom_range(0, 9);
      if (k <= 6)      a = base + $urandom_range(0, 63);
      else if (k <= 8) a = base + 32'hFC0 + $urandom_range(0, 63);
      else if ($urandom_range(0, 1) == 1) a = base + 32'h1000 + $urandom_range(0, 15);
      else             a = (sel == 1) ? 32'h1000 - $urandom_range(1, 16) : $urandom;
      w  = 1'($urandom_range(0, 1));
      fn = 3'($urandom_range(0, 7));
      if (w && (fn == 3'b100 || fn == 3'b101)) fn = {1'b0, fn[1:0]};
      xact(w, fn, a, $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic reset_in_resp();
    logic e;
    logic [31:0] r;
    int unsigned l;
    model(1'b1, 3'b010, 32'((sel == 1) ? 32'h1000 : 0) + 32'h20, 32'hCAFE_F00D, e, r, l);
    @(negedge clk);
    valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = ((sel == 1) ? 32'h1000 : 32'h0) + 32'h20; wd = 32'hCAFE_F00D;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", o_rv, 1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", o_rv, 0);
    check("rst_req_ready", o_qr, 1);
    check("rst_rdata", o_rd, 0);
    check("rst_err", o_er, 0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 3'b010, ((sel == 1) ? 32'h1000 : 32'h0) + 32'h20, 0, 0);
  endtask

  task automatic reset_in_rd1();
    @(negedge clk);
    valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h1010; wd = '0;
    @(posedge clk);
    #1 valid = 1'b0;
    check("rd1_valid", o_rv, 0);
    check("rd1_ready", o_qr, 0);
    rst_n = 1'b0;
    #1;
    check("rst_rd1_ready", o_qr, 1);
    check("rst_rd1_valid", o_rv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rd1_no_resp", o_rv, 0);
  endtask

  initial begin
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset_req_ready", o_qr, 1);
      check("reset_resp_valid", o_rv, 0);
      check("reset_rdata", o_rd, 0);
      check("reset_err", o_er, 0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      preinit();
      if (s == 0) begin
        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        xact(1'b0, 3'b010, 32'h10, 0, 0);
        xact(1'b1, 3'b000, 32'h12, 32'h0000_005A, 0);
        xact(1'b0, 3'b010, 32'h10, 0, 0);
        xact(1'b0, 3'b000, 32'h13, 0, 0);
        xact(1'b0, 3'b100, 32'h13, 0, 0);
        xact(1'b0, 3'b001, 32'h12, 0, 0);
        xact(1'b0, 3'b101, 32'h10, 0, 0);
        xact(1'b1, 3'b001, 32'h11, 32'h1234_5678, 0);
        xact(1'b0, 3'b010, 32'h12, 0, 0);
        xact(1'b0, 3'b010, 32'h10, 0, 0);
        xact(1'b0, 3'b011, 32'h10, 0, 0);
        xact(1'b1, 3'b010, 32'h1000, 32'h5555_5555, 0);
        xact(1'b0, 3'b010, 32'h0, 0, 0);
        xact(1'b1, 3'b010, 32'hFFC, 32'h0BAD_F00D, 0);
        xact(1'b0, 3'b010, 32'hFFC, 0, 0);
        xact(1'b0, 3'b010, 32'h10, 0, 5);
        xact(1'b0, 3'b010, 32'h0, 0, 0);
      end else begin
        xact(1'b1, 3'b010, 32'h1010, 32'hDEAD_BEEF, 0);
        xact(1'b0, 3'b010, 32'h1010, 0, 0);
        xact(1'b0, 3'b000, 32'h1013, 0, 0);
        xact(1'b0, 3'b101, 32'h1012, 0, 0);
        xact(1'b1, 3'b010, 32'h0FFC, 32'h7777_7777, 0);
        xact(1'b0, 3'b010, 32'h1FFC, 0, 0);
        xact(1'b0, 3'b010, 32'h2000, 0, 0);
        xact(1'b0, 3'b001, 32'h1012, 0, 5);
        xact(1'b0, 3'b010, 32'h1000, 0, 0);
        reset_in_rd1();
      end
      reset_in_resp();
      random_ops(150);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
